// File: rtl/game_pkg.sv
// Shared game constants: state encoding, key box origins and object size.
// Used by the tracker, the renderer and the top-level game FSM.
package game_pkg;

  localparam logic [3:0] GsTitle    = 4'd0;
  localparam logic [3:0] GsStaff    = 4'd1;
  localparam logic [3:0] GsStage1   = 4'd2;
  localparam logic [3:0] GsSuccess1 = 4'd3;
  localparam logic [3:0] GsStage2   = 4'd4;
  localparam logic [3:0] GsSuccess2 = 4'd5;
  localparam logic [3:0] GsStage3   = 4'd6;
  localparam logic [3:0] GsSuccess3 = 4'd7;
  localparam logic [3:0] GsFail     = 4'd8;

  localparam int unsigned ObjW = 20;

  localparam logic [8:0] Key1X = 9'd65;
  localparam logic [8:0] Key1Y = 9'd35;
  localparam logic [8:0] Key2X = 9'd235;
  localparam logic [8:0] Key2Y = 9'd35;
  localparam logic [8:0] Key3X = 9'd235;
  localparam logic [8:0] Key3Y = 9'd205;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StClear,
    StDead
  } trk_state_e;

  function automatic logic is_stage(logic [3:0] s);
    return (s == GsStage1) || (s == GsStage2) || (s == GsStage3);
  endfunction

  function automatic logic [1:0] popcount3(logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Strict axis-aligned overlap of a W-square player box with a W-square object box.
module box_overlap #(
  parameter int unsigned W = 20
) (
  input  logic [8:0] px_i,
  input  logic [8:0] py_i,
  input  logic [8:0] kx_i,
  input  logic [8:0] ky_i,
  output logic       hit_o
);

  localparam logic [9:0] WExt = 10'(W);

  // Widened to 10 bits so x+W near the right edge cannot wrap.
  logic [9:0] px_w, py_w, kx_w, ky_w;
  assign px_w = {1'b0, px_i};
  assign py_w = {1'b0, py_i};
  assign kx_w = {1'b0, kx_i};
  assign ky_w = {1'b0, ky_i};

  assign hit_o = (px_w < kx_w + WExt) && (px_w + WExt > kx_w) &&
                 (py_w < ky_w + WExt) && (py_w + WExt > ky_w);

endmodule

// File: rtl/obj_tracker.sv
// Key pickup, light timer and life bookkeeping for one stage; emits clear/fail pulses.
module obj_tracker
  import game_pkg::*;
#(
  parameter int unsigned LIGHT_FRAMES = 600,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned OBJ_W        = ObjW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       frame_tick,
  input  logic       pos_valid,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  output logic [2:0] todo,
  output logic [1:0] keys_held,
  output logic [1:0] life,
  output logic       light_on,
  output logic       stage_clear,
  output logic       fail
);

  localparam logic [9:0] LightInit = 10'(LIGHT_FRAMES);
  localparam logic [1:0] LifeInit  = 2'(LIVES);

  trk_state_e fsm_q, fsm_d;
  logic [3:0] state_q;
  logic [2:0] todo_q, todo_d;
  logic [1:0] keys_q, keys_d;
  logic [1:0] life_q, life_d;
  logic [9:0] timer_q, timer_d;
  logic       clear_q, clear_d;
  logic       fail_q, fail_d;

  logic [2:0] ovl;
  logic [2:0] hit;
  logic       pickup;
  logic       entry;
  logic [2:0] keys_sum;

  box_overlap #(.W(OBJ_W)) u_key1 (
    .px_i (player_x),
    .py_i (player_y),
    .kx_i (Key1X),
    .ky_i (Key1Y),
    .hit_o(ovl[0])
  );

  box_overlap #(.W(OBJ_W)) u_key2 (
    .px_i (player_x),
    .py_i (player_y),
    .kx_i (Key2X),
    .ky_i (Key2Y),
    .hit_o(ovl[1])
  );

  box_overlap #(.W(OBJ_W)) u_key3 (
    .px_i (player_x),
    .py_i (player_y),
    .kx_i (Key3X),
    .ky_i (Key3Y),
    .hit_o(ovl[2])
  );

  assign entry    = is_stage(state) && (state != state_q);
  assign hit      = pos_valid ? (ovl & todo_q) : 3'b000;
  assign pickup   = |hit;
  assign keys_sum = {1'b0, keys_q} + {1'b0, popcount3(hit)};

  always_comb begin
    fsm_d   = fsm_q;
    todo_d  = todo_q;
    keys_d  = keys_q;
    life_d  = life_q;
    timer_d = timer_q;
    clear_d = 1'b0;
    fail_d  = 1'b0;

    if (!is_stage(state)) begin
      fsm_d = StIdle;
    end else if (entry) begin
      fsm_d   = StArmed;
      todo_d  = 3'b111;
      keys_d  = 2'd0;
      life_d  = LifeInit;
      timer_d = LightInit;
    end else if (fsm_q == StArmed) begin
      todo_d = todo_q & ~hit;
      keys_d = keys_sum[1:0];
      // A pickup reload takes precedence over a same-cycle frame tick.
      if (pickup) begin
        timer_d = LightInit;
      end else if (frame_tick && (timer_q != 10'd0)) begin
        if (timer_q == 10'd1) begin
          life_d  = life_q - 2'd1;
          timer_d = (life_q == 2'd1) ? 10'd0 : LightInit;
        end else begin
          timer_d = timer_q - 10'd1;
        end
      end
      if (keys_sum == 3'd3) begin
        fsm_d   = StClear;
        clear_d = 1'b1;
      end else if (life_d == 2'd0) begin
        fsm_d  = StDead;
        fail_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      state_q <= GsTitle;
      todo_q  <= 3'b111;
      keys_q  <= 2'd0;
      life_q  <= LifeInit;
      timer_q <= LightInit;
      clear_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state;
      todo_q  <= todo_d;
      keys_q  <= keys_d;
      life_q  <= life_d;
      timer_q <= timer_d;
      clear_q <= clear_d;
      fail_q  <= fail_d;
    end
  end

  assign todo        = todo_q;
  assign keys_held   = keys_q;
  assign life        = life_q;
  assign light_on    = (timer_q != 10'd0);
  assign stage_clear = clear_q;
  assign fail        = fail_q;

endmodule

// File: tb/tb_obj_tracker.sv
// Scoreboard bench for obj_tracker: driver pushes model predictions, monitor compares per cycle.
`timescale 1ns / 100ps
module tb_obj_tracker;

  localparam int LF = 4;
  localparam int LV = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state = 4'd0;
  logic       frame_tick = 1'b0;
  logic       pos_valid = 1'b0;
  logic [8:0] player_x = 9'd0;
  logic [8:0] player_y = 9'd0;
  logic [2:0] todo;
  logic [1:0] keys_held;
  logic [1:0] life;
  logic       light_on;
  logic       stage_clear;
  logic       fail;

  obj_tracker #(
    .LIGHT_FRAMES(LF),
    .LIVES       (LV),
    .OBJ_W       (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .frame_tick (frame_tick),
    .pos_valid  (pos_valid),
    .player_x   (player_x),
    .player_y   (player_y),
    .todo       (todo),
    .keys_held  (keys_held),
    .life       (life),
    .light_on   (light_on),
    .stage_clear(stage_clear),
    .fail       (fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    todo;
    int    keys;
    int    life;
    int    light;
    int    clr;
    int    fl;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: plain integers, phase 0=idle 1=armed 2=frozen.
  int m_todo, m_keys, m_life, m_timer, m_phase, m_prev;
  int kx[3] = '{65, 235, 235};
  int ky[3] = '{35, 35, 205};

  function automatic bit stage_val(int s);
    return (s == 2) || (s == 4) || (s == 6);
  endfunction

  function automatic bit touches(int px, int py, int k);
    return (px < kx[k] + 20) && (px + 20 > kx[k]) && (py < ky[k] + 20) && (py + 20 > ky[k]);
  endfunction

  function automatic void model_reset();
    m_todo = 7; m_keys = 0; m_life = LV; m_timer = LF; m_phase = 0; m_prev = 0;
  endfunction

  function automatic void model_step(int st, bit pv, int x, int y, bit ft, string tag);
    exp_t e;
    bit   got = 0;
    e.clr = 0;
    e.fl  = 0;
    if (!stage_val(st)) begin
      m_phase = 0;
    end else if (st != m_prev) begin
      m_phase = 1; m_todo = 7; m_keys = 0; m_life = LV; m_timer = LF;
    end else if (m_phase == 1) begin
      if (pv) begin
        for (int k = 0; k < 3; k++) begin
          if (m_todo[k] && touches(x, y, k)) begin
            m_todo[k] = 1'b0;
            m_keys++;
            got = 1;
          end
        end
      end
      if (got) m_timer = LF;
      else if (ft && m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) begin
          m_life--;
          if (m_life > 0) m_timer = LF;
        end
      end
      if (m_keys == 3) begin
        m_phase = 2; e.clr = 1;
      end else if (m_life == 0) begin
        m_phase = 2; e.fl = 1;
      end
    end
    m_prev  = st;
    e.todo  = m_todo;
    e.keys  = m_keys;
    e.life  = m_life;
    e.light = (m_timer != 0);
    e.tag   = tag;
    exp_q.push_back(e);
  endfunction

  task automatic step(input int st, input bit pv, input int x, input int y, input bit ft,
                      input string tag);
    state      = st[3:0];
    pos_valid  = pv;
    player_x   = x[8:0];
    player_y   = y[8:0];
    frame_tick = ft;
    @(posedge clk);
    model_step(st, pv, x, y, ft, tag);
    #1;
    pos_valid  = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    vectors++;
    if (todo !== 3'b111 || keys_held !== 2'd0 || life !== 2'(LV) || light_on !== 1'b1 ||
        stage_clear !== 1'b0 || fail !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got todo=%b keys=%0d life=%0d light=%b clr=%b fail=%b, want 111/0/%0d/1/0/0",
               tag, todo, keys_held, life, light_on, stage_clear, fail, LV);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (todo !== 3'(e.todo) || keys_held !== 2'(e.keys) || life !== 2'(e.life) ||
          light_on !== 1'(e.light) || stage_clear !== 1'(e.clr) || fail !== 1'(e.fl)) begin
        miscompares++;
        $display("FAIL %s @%0t: got todo=%b keys=%0d life=%0d light=%b clr=%b fail=%b, want %b/%0d/%0d/%0d/%0d/%0d",
                 e.tag, $time, todo, keys_held, life, light_on, stage_clear, fail,
                 3'(e.todo), e.keys, e.life, e.light, e.clr, e.fl);
      end
    end
  end

  function automatic int clip(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  initial begin
    int st;
    int k;
    model_reset();
    #12;
    check_reset("reset_values");
    rst_n = 1'b1;
    @(negedge clk);

    // Entry, with pos_valid in the entry cycle ignored, then key1.
    step(0, 0, 0, 0, 0, "title");
    step(2, 1, 70, 40, 0, "entry_ignores_pos");
    step(2, 1, 70, 40, 0, "key1");
    step(2, 1, 70, 40, 0, "key1_retouch");
    step(2, 1, 240, 40, 0, "key2");
    step(2, 1, 240, 210, 0, "key3_clear");
    for (int i = 0; i < 6; i++) step(2, 0, 0, 0, 1, "clear_frozen");

    // Re-enter stage 1 and probe the x boundaries of key1.
    step(3, 0, 0, 0, 0, "success1");
    step(2, 0, 0, 0, 0, "reenter");
    step(2, 1, 45, 40, 0, "bound_45");
    step(2, 1, 85, 40, 0, "bound_85");
    step(2, 1, 70, 55, 0, "bound_y55");
    step(2, 1, 46, 40, 0, "bound_46");

    // Light runs out three times.
    step(4, 0, 0, 0, 0, "stage2_entry");
    for (int i = 1; i <= 12; i++) step(4, 0, 0, 0, 1, $sformatf("tick_%0d", i));
    for (int i = 0; i < 4; i++) step(4, 0, 0, 0, 1, "dead_frozen");

    // Pickup on the tick that would cost a life.
    step(5, 0, 0, 0, 0, "success2");
    step(6, 0, 0, 0, 0, "stage3_entry");
    for (int i = 0; i < 3; i++) step(6, 0, 0, 0, 1, "pre_tick");
    step(6, 1, 240, 210, 1, "tick_and_pickup");
    for (int i = 0; i < 4; i++) step(6, 0, 0, 0, 1, "post_reload_tick");

    // Randomised play.
    st = 2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) st = $urandom_range(0, 8);
      k = $urandom_range(0, 2);
      step(st, $urandom_range(0, 2) == 0,
           clip(kx[k] - 22 + $urandom_range(0, 44), 319),
           clip(ky[k] - 22 + $urandom_range(0, 44), 239),
           $urandom_range(0, 1) == 1, "random");
    end

    // Mid-stage asynchronous reset, then 3 -> 4 re-arms.
    step(2, 0, 0, 0, 0, "pre_reset_a");
    step(2, 1, 70, 40, 0, "pre_reset_b");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    #0.5 check_reset("async_reset");
    step(3, 0, 0, 0, 0, "post_reset_success1");
    step(4, 0, 0, 0, 0, "post_reset_stage2");
    step(4, 1, 240, 40, 0, "post_reset_key2");

    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
